// File: rtl/copro_issuer.sv
`default_nettype none
// ============================================================================
// Module   : copro_issuer
// Purpose  : Command FIFO and issue FSM feeding the matrix coprocessor; parks
//            it on NOP after each instruction and returns one response each.
//            Optional WAIT/RSTW timeout: define COPRO_ISSUER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module copro_issuer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [17:0] cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [17:0] copro_instruction,
    output logic        copro_wr,
    input  logic [7:0]  copro_data,
    input  logic        copro_done,
    input  logic        copro_overflow,
    input  logic        copro_addr_err,
    output logic        resp_valid,
    output logic [2:0]  resp_opcode,
    output logic [7:0]  resp_data,
    output logic [2:0]  resp_flags,
    output logic        busy
);

    localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam int c_cnt_lim = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_lim + 1);
    localparam logic [c_ptr_w:0]   c_depth    = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_rst_last = c_cnt_w'(RST_CYCLES - 1);
`ifdef COPRO_ISSUER_TIMEOUT_EN
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(c_cnt_lim);
    localparam logic [c_cnt_w-1:0] c_to_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);
`else
    // Without the timeout the counter only has to cover the RST hold window.
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'((RST_CYCLES > 1) ? RST_CYCLES : 1);
`endif

    localparam logic [2:0]  c_op_nop   = 3'b000;
    localparam logic [2:0]  c_op_load  = 3'b001;
    localparam logic [2:0]  c_op_store = 3'b010;
    localparam logic [2:0]  c_op_rst   = 3'b111;
    localparam logic [17:0] c_nop      = 18'h0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RSTW = 2'd2,
        S_PARK = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [17:0]          r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_ptr_w:0]     r_count;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic [17:0]          r_instr, w_instr_nxt;
    logic                 r_wr, w_wr_nxt;
    logic [2:0]           r_cur_op, w_cur_op_nxt;
    logic                 r_resp_valid, w_resp_valid_nxt;
    logic [2:0]           r_resp_op, w_resp_op_nxt;
    logic [7:0]           r_resp_data, w_resp_data_nxt;
    logic [2:0]           r_resp_flags, w_resp_flags_nxt;
    logic                 w_full, w_empty, w_push, w_pop;
    logic [17:0]          w_head;
    logic [2:0]           w_head_op;

    assign w_full    = (r_count == c_depth);
    assign w_empty   = (r_count == '0);
    assign w_push    = cmd_valid & ~w_full;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_head_op = w_head[2:0];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_instr_nxt      = r_instr;
        w_wr_nxt         = 1'b0;
        w_cur_op_nxt     = r_cur_op;
        w_pop            = 1'b0;
        w_resp_valid_nxt = 1'b0;
        w_resp_op_nxt    = r_resp_op;
        w_resp_data_nxt  = r_resp_data;
        w_resp_flags_nxt = r_resp_flags;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_cnt_nxt = '0;
                    if (w_head_op == c_op_nop) begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_op_nxt    = c_op_nop;
                        w_resp_data_nxt  = 8'h0;
                        w_resp_flags_nxt = 3'b000;
                    end else begin
                        w_instr_nxt  = w_head;
                        w_wr_nxt     = (w_head_op == c_op_store);
                        w_cur_op_nxt = w_head_op;
                        w_state_nxt  = (w_head_op == c_op_rst) ? S_RSTW : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt != c_cnt_max) w_cnt_nxt = r_cnt + c_cnt_w'(1);
                // Done is stale during the first WAIT cycle (coprocessor registers it).
                if ((r_cnt != '0) && copro_done) begin
                    w_instr_nxt      = c_nop;
                    w_state_nxt      = S_PARK;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_op_nxt    = r_cur_op;
                    w_resp_data_nxt  = (r_cur_op == c_op_load) ? copro_data : 8'h0;
                    w_resp_flags_nxt = {1'b0, copro_overflow, copro_addr_err};
                end
`ifdef COPRO_ISSUER_TIMEOUT_EN
                else if (r_cnt == c_to_last) begin
                    w_instr_nxt      = c_nop;
                    w_state_nxt      = S_PARK;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_op_nxt    = r_cur_op;
                    w_resp_data_nxt  = 8'h0;
                    w_resp_flags_nxt = 3'b100;
                end
`endif
            end
            S_RSTW: begin
                if (r_cnt != c_cnt_max) w_cnt_nxt = r_cnt + c_cnt_w'(1);
                if (r_cnt == c_rst_last) begin
                    w_instr_nxt      = c_nop;
                    w_state_nxt      = S_PARK;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_op_nxt    = r_cur_op;
                    w_resp_data_nxt  = 8'h0;
                    w_resp_flags_nxt = 3'b000;
                end
`ifdef COPRO_ISSUER_TIMEOUT_EN
                else if (r_cnt == c_to_last) begin
                    w_instr_nxt      = c_nop;
                    w_state_nxt      = S_PARK;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_op_nxt    = r_cur_op;
                    w_resp_data_nxt  = 8'h0;
                    w_resp_flags_nxt = 3'b100;
                end
`endif
            end
            S_PARK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_instr      <= c_nop;
            r_wr         <= 1'b0;
            r_cur_op     <= c_op_nop;
            r_resp_valid <= 1'b0;
            r_resp_op    <= 3'b000;
            r_resp_data  <= 8'h0;
            r_resp_flags <= 3'b000;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_instr      <= w_instr_nxt;
            r_wr         <= w_wr_nxt;
            r_cur_op     <= w_cur_op_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_op    <= w_resp_op_nxt;
            r_resp_data  <= w_resp_data_nxt;
            r_resp_flags <= w_resp_flags_nxt;
        end
    end

    assign cmd_ready         = ~w_full;
    assign copro_instruction = r_instr;
    assign copro_wr          = r_wr;
    assign resp_valid        = r_resp_valid;
    assign resp_opcode       = r_resp_op;
    assign resp_data         = r_resp_data;
    assign resp_flags        = r_resp_flags;
    assign busy              = (r_state != S_IDLE) | ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_copro_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_copro_issuer
// Purpose  : Directed scoreboard bench for copro_issuer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_copro_issuer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] cmd_data = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [17:0] copro_instruction;
    logic        copro_wr;
    logic [7:0]  copro_data = '0;
    logic        copro_done = 1'b0;
    logic        copro_overflow = 1'b0;
    logic        copro_addr_err = 1'b0;
    logic        resp_valid;
    logic [2:0]  resp_opcode;
    logic [7:0]  resp_data;
    logic [2:0]  resp_flags;
    logic        busy;

    copro_issuer #(
        .FIFO_DEPTH     (4),
        .RST_CYCLES     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_data          (cmd_data),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .copro_instruction (copro_instruction),
        .copro_wr          (copro_wr),
        .copro_data        (copro_data),
        .copro_done        (copro_done),
        .copro_overflow    (copro_overflow),
        .copro_addr_err    (copro_addr_err),
        .resp_valid        (resp_valid),
        .resp_opcode       (resp_opcode),
        .resp_data         (resp_data),
        .resp_flags        (resp_flags),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] data;
        logic [2:0] flags;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_e;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_resp(input logic [2:0] op, input logic [7:0] data, input logic [2:0] flags);
        resp_t e;
        e.op    = op;
        e.data  = data;
        e.flags = flags;
        exp_q.push_back(e);
    endtask

    // Monitor: every response pulse is checked against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got op=%0h data=%0h flags=%0h, required no response",
                         resp_opcode, resp_data, resp_flags);
            end else begin
                mon_e = exp_q.pop_front();
                if ({resp_opcode, resp_data, resp_flags} !== mon_e) begin
                    errors++;
                    $display("FAIL resp_fields: got op=%0h data=%0h flags=%0h, required op=%0h data=%0h flags=%0h",
                             resp_opcode, resp_data, resp_flags, mon_e.op, mon_e.data, mon_e.flags);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [17:0] d);
        int n;
        n = 0;
        cmd_data  = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got cmd_ready=0, required 1 within 200 cycles");
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || resp_valid || exp_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending responses, required 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instr", copro_instruction, 18'h0);
        chk("rst_wr", copro_wr, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of WAIT; no response may follow
        push(18'h00013);
        tick();
        chk("add_issue", copro_instruction, 18'h00013);
        chk("add_busy", busy, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        chk("midrst_instr", copro_instruction, 18'h0);
        chk("midrst_wr", copro_wr, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", cmd_ready, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        copro_done = 1'b1;
        repeat (4) tick();
        copro_done = 1'b0;
        chk("midrst_idle", busy, 1'b0);

        // LOAD returns data, NOP driven on the done edge
        wait_idle();
        expect_resp(3'b001, 8'hA5, 3'b000);
        push(18'h00009);
        tick();
        chk("load_issue", copro_instruction, 18'h00009);
        chk("load_wr", copro_wr, 1'b0);
        repeat (5) tick();
        chk("load_hold", copro_instruction, 18'h00009);
        copro_data = 8'hA5;
        copro_done = 1'b1;
        tick();
        chk("load_done_nop", copro_instruction, 18'h0);
        copro_done = 1'b0;

        // STORE: one-cycle write strobe, stale done ignored
        wait_idle();
        expect_resp(3'b010, 8'h00, 3'b000);
        copro_done = 1'b1;
        push(18'h000A2);
        tick();
        chk("store_issue", copro_instruction, 18'h000A2);
        chk("store_wr", copro_wr, 1'b1);
        tick();
        chk("store_wr_drop", copro_wr, 1'b0);
        chk("store_stale_done", copro_instruction, 18'h000A2);
        copro_done = 1'b0;
        tick();
        tick();
        chk("store_hold", copro_instruction, 18'h000A2);
        copro_done = 1'b1;
        tick();
        chk("store_done_nop", copro_instruction, 18'h0);
        copro_done = 1'b0;

        // FIFO fill with stalled coprocessor, mixed opcodes, in-order responses
        wait_idle();
        copro_data = 8'h5A;
        expect_resp(3'b011, 8'h00, 3'b000);
        expect_resp(3'b011, 8'h00, 3'b000);
        expect_resp(3'b001, 8'h5A, 3'b000);
        expect_resp(3'b000, 8'h00, 3'b000);
        expect_resp(3'b011, 8'h00, 3'b000);
        expect_resp(3'b011, 8'h00, 3'b000);
        push(18'h00113);
        push(18'h00213);
        push(18'h00309);
        push(18'h00400);
        push(18'h00513);
        chk("fifo_full", cmd_ready, 1'b0);
        chk("fifo_busy", busy, 1'b1);
        cmd_data  = 18'h00613;
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fifo_refuse", cmd_ready, 1'b0);
        end
        chk("fifo_stall_hold", copro_instruction, 18'h00113);
        copro_done = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        chk("fifo_reopen", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        wait_idle();
        copro_done = 1'b0;

        // RST held exactly four cycles despite done stuck high
        expect_resp(3'b111, 8'h00, 3'b000);
        copro_done = 1'b1;
        push(18'h00007);
        tick();
        chk("rstop_issue", copro_instruction, 18'h00007);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rstop_hold", copro_instruction, 18'h00007);
        end
        tick();
        chk("rstop_release", copro_instruction, 18'h0);
        copro_done = 1'b0;

        // ADD with overflow, LOAD with address error
        wait_idle();
        expect_resp(3'b011, 8'h00, 3'b010);
        copro_overflow = 1'b1;
        push(18'h00023);
        repeat (3) tick();
        copro_done = 1'b1;
        tick();
        chk("ovf_done_nop", copro_instruction, 18'h0);
        copro_done     = 1'b0;
        copro_overflow = 1'b0;
        wait_idle();
        expect_resp(3'b001, 8'h3C, 3'b001);
        copro_addr_err = 1'b1;
        copro_data     = 8'h3C;
        push(18'h00031);
        tick();
        tick();
        copro_done = 1'b1;
        tick();
        chk("aerr_done_nop", copro_instruction, 18'h0);
        copro_done     = 1'b0;
        copro_addr_err = 1'b0;

        // MULM never completes
        wait_idle();
        copro_data = 8'h5A;
`ifdef COPRO_ISSUER_TIMEOUT_EN
        expect_resp(3'b100, 8'h00, 3'b100);
        push(18'h00044);
        tick();
        chk("mulm_issue", copro_instruction, 18'h00044);
        repeat (7) tick();
        chk("mulm_hold", copro_instruction, 18'h00044);
        tick();
        chk("mulm_timeout_nop", copro_instruction, 18'h0);
`else
        expect_resp(3'b100, 8'h00, 3'b000);
        push(18'h00044);
        tick();
        chk("mulm_issue", copro_instruction, 18'h00044);
        repeat (20) tick();
        chk("mulm_no_timeout", copro_instruction, 18'h00044);
        copro_done = 1'b1;
        tick();
        chk("mulm_done_nop", copro_instruction, 18'h0);
        copro_done = 1'b0;
`endif
        wait_idle();
        chk("resp_count", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
